// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// State and owner encodings live here so the FSM, the hold counter and any
// bench see one definition.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_EXT  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } owner_e;

    // Counter width that can hold MAX_HOLD-1; never narrower than one bit.
    function automatic int unsigned hold_width(input int unsigned max_hold);
        return (max_hold > 1) ? $clog2(max_hold) : 1;
    endfunction

    // True when the word index of a byte address lies inside data memory.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input int unsigned words);
        return 32'(addr[31:2]) < words;
    endfunction

endpackage

// File: rtl/dmem_arbiter_hold_cnt.sv
// arb_hold_cnt: saturating count of consecutive granted cycles during which
// the non-owning side is waiting. at_limit flags MAX_HOLD-1, the point at
// which the owner must hand the port over.
module arb_hold_cnt
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic at_limit
);

    localparam int unsigned W = hold_width(MAX_HOLD);
    localparam logic [W-1:0] LIMIT = W'(MAX_HOLD - 1);

    logic [W-1:0] cnt;

    // Clear has priority over count; counting stops once the limit is held.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU load/store unit
// and an external loader/debug master. Ownership is a registered FSM with a
// bounded hold time; writes whose word index is out of range are dropped and
// reported on oob_err.
// Build option: define DMEM_ARB_RR_EN for a round-robin IDLE tie-break;
// otherwise CPU wins every IDLE tie.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD   = 4,
    parameter int unsigned ADDR_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_byte_en,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic [31:0] cpu_rdata,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [3:0]  ext_byte_en,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    output logic        ext_gnt,
    output logic [31:0] ext_rdata,
    output logic        mem_write,
    output logic [3:0]  mem_byte_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        oob_err
);

`ifdef DMEM_ARB_RR_EN
    localparam logic FIXED_CPU_PRIO = 1'b0;
`else
    localparam logic FIXED_CPU_PRIO = 1'b1;
`endif

    state_e state;
    state_e state_nxt;
    owner_e last_owner;

    logic tie_to_cpu;
    logic other_req;
    logic hold_clr;
    logic at_limit;
    logic owner_req;
    logic owner_we;
    logic granted_write;
    logic in_range;

    // With fixed priority the constant forces CPU; otherwise the side that
    // did not own the port last wins.
    assign tie_to_cpu = FIXED_CPU_PRIO | (last_owner == OWN_EXT);

    // Next owner: IDLE arbitration, voluntary release and forced hand-over.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (cpu_req && ext_req) begin
                    state_nxt = tie_to_cpu ? ST_CPU : ST_EXT;
                end else if (cpu_req) begin
                    state_nxt = ST_CPU;
                end else if (ext_req) begin
                    state_nxt = ST_EXT;
                end
            end
            ST_CPU: begin
                if (!cpu_req) begin
                    state_nxt = ext_req ? ST_EXT : ST_IDLE;
                end else if (ext_req && at_limit) begin
                    state_nxt = ST_EXT;
                end
            end
            ST_EXT: begin
                if (!ext_req) begin
                    state_nxt = cpu_req ? ST_CPU : ST_IDLE;
                end else if (cpu_req && at_limit) begin
                    state_nxt = ST_CPU;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Hold time only accumulates while the current owner keeps the port and
    // the other side is waiting.
    always_comb begin
        other_req = 1'b0;
        if (state == ST_CPU) begin
            other_req = ext_req;
        end else if (state == ST_EXT) begin
            other_req = cpu_req;
        end
        hold_clr = (state == ST_IDLE) || (state_nxt != state) || !other_req;
    end

    arb_hold_cnt #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold (
        .clk      (clk),
        .reset    (reset),
        .clr      (hold_clr),
        .en       (1'b1),
        .at_limit (at_limit)
    );

    // Port mux: EXT inputs only while EXT owns the port, CPU inputs otherwise.
    always_comb begin
        if (ext_gnt) begin
            mem_addr    = ext_addr;
            mem_byte_en = ext_byte_en;
            mem_wdata   = ext_wdata;
            owner_req   = ext_req;
            owner_we    = ext_we;
        end else begin
            mem_addr    = cpu_addr;
            mem_byte_en = cpu_byte_en;
            mem_wdata   = cpu_wdata;
            owner_req   = cpu_req & cpu_gnt;
            owner_we    = cpu_we;
        end
        in_range      = addr_in_range(mem_addr, ADDR_WORDS);
        granted_write = (cpu_gnt | ext_gnt) & owner_req & owner_we;
        // Reset is asserted before the edge, so gating here keeps the memory
        // from committing a write on the reset edge of an aborted grant.
        mem_write     = granted_write & in_range & !reset;
    end

    // Reads are never blocked; each side qualifies data with its own grant.
    assign cpu_rdata = mem_rdata;
    assign ext_rdata = mem_rdata;

    // Ownership FSM with registered grants, owner history and error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cpu_gnt    <= 1'b0;
            ext_gnt    <= 1'b0;
            last_owner <= OWN_EXT;
            oob_err    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cpu_gnt <= (state_nxt == ST_CPU);
            ext_gnt <= (state_nxt == ST_EXT);
            if (state_nxt != state) begin
                if (state_nxt == ST_CPU) begin
                    last_owner <= OWN_CPU;
                end else if (state_nxt == ST_EXT) begin
                    last_owner <= OWN_EXT;
                end
            end
            oob_err <= granted_write & !in_range;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a byte-enabled memory model sits on
// the memory port; expected read data and grant sequences are queued when
// stimulus is applied and popped when the DUT answers.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, ext_req, ext_we;
    logic [3:0]  cpu_byte_en, ext_byte_en, mem_byte_en;
    logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
    logic        cpu_gnt, ext_gnt, mem_write, oob_err;
    logic [31:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;

    logic        mem_init;
    logic [31:0] mem     [32];
    logic [31:0] ref_mem [32];

    logic [31:0] rd_q  [$];
    logic [1:0]  gnt_q [$];

    always #5 clk = ~clk;

    dmem_arbiter #(
        .MAX_HOLD   (4),
        .ADDR_WORDS (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_byte_en (cpu_byte_en),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_rdata   (cpu_rdata),
        .ext_req     (ext_req),
        .ext_we      (ext_we),
        .ext_byte_en (ext_byte_en),
        .ext_addr    (ext_addr),
        .ext_wdata   (ext_wdata),
        .ext_gnt     (ext_gnt),
        .ext_rdata   (ext_rdata),
        .mem_write   (mem_write),
        .mem_byte_en (mem_byte_en),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .oob_err     (oob_err)
    );

    function automatic logic [31:0] init_val(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0001_0103;
    endfunction

    // Memory model: synchronous byte-enabled write, combinational read.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
        end else if (mem_write) begin
            for (int b = 0; b < 4; b++)
                if (mem_byte_en[b]) mem[mem_addr[6:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end
    assign mem_rdata = mem[mem_addr[6:2]];

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        cpu_req = 1'b0;
        ext_req = 1'b0;
        drive_edge();
        drive_edge();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        // Requests are high during reset: reset must win.
        reset = 1'b1; mem_init = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0; cpu_byte_en = 4'hF; cpu_wdata = 32'hFFFF_FFFF;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h4; ext_byte_en = 4'hF; ext_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
        drive_edge(); drive_edge(); drive_edge();
        mem_init = 1'b0;
        sample();
        checks++;
        if ({cpu_gnt, ext_gnt, mem_write, oob_err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got gnt=%b%b write=%b oob=%b want all 0", cpu_gnt, ext_gnt, mem_write, oob_err);
        end
        checks++;
        if (dut.u_hold.cnt !== '0 || dut.last_owner !== OWN_EXT || dut.state !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_state got cnt=%0d owner=%0d state=%0d want 0 %0d %0d",
                     dut.u_hold.cnt, dut.last_owner, dut.state, OWN_EXT, ST_IDLE);
        end
        drive_edge();
        reset = 1'b0; cpu_req = 1'b0; ext_req = 1'b0; cpu_we = 1'b0; ext_we = 1'b0;
        drive_edge();
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8;
        rd_q.push_back(ref_mem[2]);
        sample();
        checks++;
        if (cpu_gnt !== 1'b0) begin
            failures++;
            $display("FAIL read_latency got cpu_gnt=%b want 0", cpu_gnt);
        end
        drive_edge();
        sample();
        checks++;
        if (cpu_gnt !== 1'b1 || mem_addr !== 32'h8) begin
            failures++;
            $display("FAIL read_grant got gnt=%b addr=%h want 1 00000008", cpu_gnt, mem_addr);
        end
        begin
            logic [31:0] e;
            e = rd_q.pop_front();
            checks++;
            if (cpu_rdata !== e || ext_rdata !== e) begin
                failures++;
                $display("FAIL read_data got cpu=%h ext=%h want %h", cpu_rdata, ext_rdata, e);
            end
        end
        drive_edge();
        cpu_req = 1'b0;
        drive_edge();
    endtask

    // One request on one side, with a bounded wait for the grant.
    task automatic access(input bit is_ext, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd);
        logic in_rng;
        logic got;
        logic [4:0] idx;
        in_rng = addr[31:2] < 30'd32;
        idx = addr[6:2];
        if (is_ext) begin
            ext_req = 1'b1; ext_we = we; ext_addr = addr; ext_byte_en = be; ext_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_byte_en = be; cpu_wdata = wd;
        end
        if (!we) rd_q.push_back(ref_mem[idx]);
        else if (in_rng)
            for (int b = 0; b < 4; b++) if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
        got = 1'b0;
        for (int n = 0; n < 16 && !got; n++) begin
            drive_edge();
            sample();
            got = is_ext ? ext_gnt : cpu_gnt;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL access_grant_timeout side=%0d addr=%h got no grant want grant", is_ext, addr);
        end else begin
            checks++;
            if (mem_write !== (we & in_rng)) begin
                failures++;
                $display("FAIL access_write addr=%h got mem_write=%b want %b", addr, mem_write, we & in_rng);
            end
            if (!we) begin
                logic [31:0] e;
                e = rd_q.pop_front();
                checks++;
                if ((is_ext ? ext_rdata : cpu_rdata) !== e) begin
                    failures++;
                    $display("FAIL access_rdata addr=%h got %h want %h", addr, is_ext ? ext_rdata : cpu_rdata, e);
                end
            end
        end
        drive_edge();
        if (is_ext) ext_req = 1'b0; else cpu_req = 1'b0;
        sample();
        checks++;
        if (oob_err !== (we & !in_rng & got)) begin
            failures++;
            $display("FAIL access_oob addr=%h got oob_err=%b want %b", addr, oob_err, we & !in_rng & got);
        end
        drive_edge();
        sample();
        checks++;
        if (oob_err !== 1'b0) begin
            failures++;
            $display("FAIL access_oob_pulse addr=%h got oob_err=%b want 0", addr, oob_err);
        end
        drive_edge();
    endtask

    task automatic test_mem_contents(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mem_contents_%s got %0d differing words want 0", tag, bad);
        end
    endtask

    task automatic test_writes();
        access(0, 1'b1, 32'h10, 4'b0101, 32'hAABB_CCDD);
        access(1, 1'b0, 32'h10, 4'hF, 32'h0);
        access(0, 1'b1, 32'h7C, 4'b1001, 32'h1122_3344);
        access(1, 1'b1, 32'h80, 4'hF, 32'hFFFF_FFFF);
        access(0, 1'b0, 32'h7C, 4'hF, 32'h0);
        test_mem_contents("writes");
    endtask

    task automatic test_hold();
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'hC;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 4; k++) gnt_q.push_back((r % 2 == 0) ? 2'b10 : 2'b01);
        for (int i = 0; i < 12; i++) begin
            logic [1:0]  e;
            logic [31:0] ea;
            drive_edge();
            sample();
            e = gnt_q.pop_front();
            ea = (e == 2'b10) ? 32'h4 : 32'hC;
            checks++;
            if ({cpu_gnt, ext_gnt} !== e || mem_addr !== ea) begin
                failures++;
                $display("FAIL hold_cycle%0d got gnt=%b%b addr=%h want %b %h", i, cpu_gnt, ext_gnt, mem_addr, e, ea);
            end
        end
        drive_edge();
        cpu_req = 1'b0; ext_req = 1'b0;
        drive_edge(); drive_edge();
    endtask

    task automatic test_reset_mid_grant();
        logic got;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h20; ext_byte_en = 4'hF; ext_wdata = 32'hCAFE_F00D;
        got = 1'b0;
        for (int n = 0; n < 16 && !got; n++) begin
            drive_edge();
            sample();
            got = ext_gnt;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL midreset_grant_timeout got no ext_gnt want grant");
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b0) begin
            failures++;
            $display("FAIL midreset_write got mem_write=%b want 0", mem_write);
        end
        drive_edge();
        ext_req = 1'b0; ext_we = 1'b0;
        checks++;
        if (cpu_gnt !== 1'b0 || ext_gnt !== 1'b0 || dut.state !== ST_IDLE || dut.u_hold.cnt !== '0 || oob_err !== 1'b0) begin
            failures++;
            $display("FAIL midreset_state got gnt=%b%b state=%0d cnt=%0d oob=%b want 00 0 0 0",
                     cpu_gnt, ext_gnt, dut.state, dut.u_hold.cnt, oob_err);
        end
        reset = 1'b0;
        drive_edge();
        test_mem_contents("midreset");
    endtask

    task automatic test_handover();
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h4;
        drive_edge();
        sample();
        checks++;
        if ({cpu_gnt, ext_gnt} !== 2'b10) begin
            failures++;
            $display("FAIL tie_after_reset got gnt=%b%b want 10", cpu_gnt, ext_gnt);
        end
        drive_edge();
        cpu_req = 1'b0;
        drive_edge();
        sample();
        checks++;
        if ({cpu_gnt, ext_gnt} !== 2'b01 || dut.u_hold.cnt !== '0) begin
            failures++;
            $display("FAIL handover got gnt=%b%b cnt=%0d want 01 0", cpu_gnt, ext_gnt, dut.u_hold.cnt);
        end
        drive_edge();
        ext_req = 1'b0;
        drive_edge(); drive_edge();
    endtask

    task automatic test_tiebreak();
        logic [1:0] e;
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b0;
        drive_edge();
        cpu_req = 1'b0;
        drive_edge();
        cpu_req = 1'b1; ext_req = 1'b1;
`ifdef DMEM_ARB_RR_EN
        gnt_q.push_back(2'b01);
`else
        gnt_q.push_back(2'b10);
`endif
        drive_edge();
        sample();
        e = gnt_q.pop_front();
        checks++;
        if ({cpu_gnt, ext_gnt} !== e) begin
            failures++;
            $display("FAIL tiebreak got gnt=%b%b want %b", cpu_gnt, ext_gnt, e);
        end
        drive_edge();
        cpu_req = 1'b0; ext_req = 1'b0;
        drive_edge(); drive_edge();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cpu_read();
        test_writes();
        test_hold();
        test_reset_mid_grant();
        test_handover();
        test_tiebreak();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
